// File: rtl/radix4_div_pkg.sv
// radix4_div_pkg: shared state encoding, width helpers and dividend approximation for radix4_seq_divider
package radix4_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    function automatic int r_width(input int n);
        return n + 2;
    endfunction
    function automatic int cnt_width(input int n);
        return $clog2(n / 2);
    endfunction
    // Low m bits collapse to a single majority bit at position m-1.
    function automatic logic [63:0] approx_m2(input logic [63:0] d, input int m);
        int ones;
        logic [63:0] r;
        ones = 0;
        r = d;
        for (int i = 0; i < 64; i++) begin
            if (i < m) begin
                ones += int'(d[i]);
                r[i] = 1'b0;
            end
        end
        if (ones > m / 2) r[m-1] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/radix4_digit_sel.sv
// radix4_digit_sel: picks the radix-4 quotient digit and the restored partial remainder
module radix4_digit_sel #(
    parameter int N = 16
) (
    input  logic [N+1:0] t,
    input  logic [N+1:0] d,
    input  logic [N+1:0] d2,
    input  logic [N+1:0] d3,
    output logic [1:0]   q,
    output logic [N-1:0] r_next
);
    logic ge1, ge2, ge3;
    logic [N+1:0] sub;
    always_comb begin
        ge3 = t >= d3;
        ge2 = t >= d2;
        ge1 = t >= d;
        q = ge3 ? 2'd3 : ge2 ? 2'd2 : ge1 ? 2'd1 : 2'd0;
        sub = ge3 ? d3 : ge2 ? d2 : ge1 ? d : '0;
        r_next = N'(t - sub);
    end
endmodule

// File: rtl/radix4_seq_divider.sv
// radix4_seq_divider: unsigned radix-4 restoring divider, 2 quotient bits per cycle; RADIX4_DIV_APPROX_EN approximates the low M dividend bits
module radix4_seq_divider
    import radix4_div_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int RW = r_width(N);
    localparam int CW = cnt_width(N);

    if (N % 2 != 0 || N < 4 || M < 2 || M > N) begin : g_bad_param
        $error("radix4_seq_divider: illegal N/M");
    end

    state_t state_q, state_d;
    logic [N-1:0] dvd_q, dvd_d, d_q, d_d, quo_q, quo_d, r_q, r_d, dvd_in, r_nx;
    logic [RW-1:0] d3_q, d3_d, t, d1, d2;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [1:0] q_dig;

`ifdef RADIX4_DIV_APPROX_EN
    assign dvd_in = N'(approx_m2(64'(dividend), M));
`else
    assign dvd_in = dividend;
`endif

    // R < D keeps the partial remainder in N bits; the next dividend pair fills the low end.
    assign t  = {r_q, dvd_q[N-1:N-2]};
    assign d1 = RW'(d_q);
    assign d2 = {1'b0, d_q, 1'b0};

    radix4_digit_sel #(.N(N)) u_sel (
        .t      (t),
        .d      (d1),
        .d2     (d2),
        .d3     (d3_q),
        .q      (q_dig),
        .r_next (r_nx)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        d_d     = d_q;
        d3_d    = d3_q;
        r_d     = r_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        if (state_q == IDLE && start) begin
            dvd_d   = dvd_in;
            d_d     = divisor;
            d3_d    = RW'(divisor) + {1'b0, divisor, 1'b0};
            dbz_d   = divisor == '0;
            quo_d   = divisor == '0 ? '1 : '0;
            r_d     = divisor == '0 ? dvd_in : '0;
            cnt_d   = CW'(N / 2 - 1);
            state_d = divisor == '0 ? FIN : CALC;
        end else if (state_q == CALC) begin
            dvd_d   = dvd_q << 2;
            r_d     = r_nx;
            quo_d   = {quo_q[N-3:0], q_dig};
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == '0 ? FIN : CALC;
        end else if (state_q == FIN) begin
            state_d = IDLE;
        end
        busy_d = state_d != IDLE;
        done_d = state_d == FIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            d_q     <= '0;
            d3_q    <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            d_q     <= d_d;
            d3_q    <= d3_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
endmodule
